// File: rtl/bit_serial_subtractor.sv
// Bit-serial A-B subtractor, one bit per cycle, LSB first.
// Registered difference, unsigned borrow and signed overflow.
module bit_serial_subtractor #(
    parameter int WIDTH = 7
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic [2*WIDTH-1:0] in,
    output logic               ready,
    output logic               done,
    output logic [WIDTH-1:0]   out,
    output logic               borrow,
    output logic               ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bin_q, bin_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    logic             a0;
    logic             b0;
    logic             dbit;
    logic             bout;
    logic             last;
    logic [WIDTH-1:0] res_sh;

    // One full-subtractor cell on the current LSBs.
    assign a0     = a_q[0];
    assign b0     = b_q[0];
    assign dbit   = a0 ^ b0 ^ bin_q;
    assign bout   = (~a0 & b0) | (~(a0 ^ b0) & bin_q);
    assign last   = (cnt_q == CW'(WIDTH - 1));
    assign res_sh = (res_q >> 1) | (WIDTH'(dbit) << (WIDTH - 1));

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        out_d    = out_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = in[WIDTH-1:0];
                    b_d     = in[2*WIDTH-1:WIDTH];
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d = res_sh;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                bin_d = bout;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    // a0/b0 now hold the operand sign bits.
                    out_d    = res_sh;
                    borrow_d = bout;
                    ovf_d    = (a0 ^ b0) & (dbit ^ a0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
        done_d  = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign out    = out_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;

endmodule
